// File: rtl/cortexm0_sleep_pmu_if.sv
// Signal bundle between the sleep PMU, the core, the WIC and the power switch.
// master = PMU side; slave = environment side (core, WIC, power switch).
interface cortexm0_sleep_pmu_if;
    logic       SLEEPING;
    logic       SLEEPDEEP;
    logic       DBGPWRUPREQ;
    logic       WAKEUP;
    logic       WICENACK;
    logic       WICENREQ;
    logic       SLEEPHOLDREQn;
    logic       SLEEPHOLDACKn;
    logic       GATEHCLK;
    logic       ISOLATEn;
    logic       RETAINn;
    logic       PWRDWNREQ;
    logic       PWRGOOD;
    logic [3:0] PMUSTATE;

    modport master (
        input  SLEEPING, SLEEPDEEP, DBGPWRUPREQ, WAKEUP, WICENACK,
               SLEEPHOLDACKn, PWRGOOD,
        output WICENREQ, SLEEPHOLDREQn, GATEHCLK, ISOLATEn, RETAINn,
               PWRDWNREQ, PMUSTATE
    );

    modport slave (
        output SLEEPING, SLEEPDEEP, DBGPWRUPREQ, WAKEUP, WICENACK,
               SLEEPHOLDACKn, PWRGOOD,
        input  WICENREQ, SLEEPHOLDREQn, GATEHCLK, ISOLATEn, RETAINn,
               PWRDWNREQ, PMUSTATE
    );
endinterface

// File: rtl/cortexm0_sleep_pmu.sv
// Always-on deep-sleep power sequencer: WIC handshake, bus hold, clock gate,
// isolation, retention and power switch control, with the reverse on wake-up.
module cortexm0_sleep_pmu #(
    parameter int ISO_DLY = 2,
    parameter int PWR_DLY = 8
) (
    input  logic                       FCLK,
    input  logic                       nRESET,
    cortexm0_sleep_pmu_if.master       pmu
);

    typedef enum logic [3:0] {
        ST_RUN     = 4'd0,
        ST_WICREQ  = 4'd1,
        ST_HOLD    = 4'd2,
        ST_GATE    = 4'd3,
        ST_ISO     = 4'd4,
        ST_RET     = 4'd5,
        ST_OFF     = 4'd6,
        ST_ON      = 4'd7,
        ST_RESTORE = 4'd8,
        ST_DEISO   = 4'd9,
        ST_UNHOLD  = 4'd10,
        ST_WICREL  = 4'd11
    } state_t;

    localparam logic [7:0] ISO_LOAD = 8'(ISO_DLY - 1);
    localparam logic [7:0] PWR_LOAD = 8'(PWR_DLY);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       wicenreq_q, wicenreq_d;
    logic       holdreqn_q, holdreqn_d;
    logic       gatehclk_q, gatehclk_d;
    logic       isolaten_q, isolaten_d;
    logic       retainn_q, retainn_d;
    logic       pwrdwnreq_q, pwrdwnreq_d;
    logic       wake_s;

    assign wake_s = pmu.WAKEUP | pmu.DBGPWRUPREQ;

    // Next-state and counter logic; handshake acks win over same-cycle aborts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (pmu.SLEEPING & pmu.SLEEPDEEP & ~pmu.DBGPWRUPREQ & ~pmu.WAKEUP) begin
                    state_d = ST_WICREQ;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_WICREQ: begin
                if (pmu.WICENACK) begin
                    state_d = ST_HOLD;
                end else if (~pmu.SLEEPING | pmu.DBGPWRUPREQ) begin
                    state_d = ST_WICREL;
                end else begin
                    state_d = ST_WICREQ;
                end
            end
            ST_HOLD: begin
                if (~pmu.SLEEPHOLDACKn) begin
                    state_d = ST_GATE;
                end else if (wake_s | ~pmu.SLEEPING) begin
                    state_d = ST_UNHOLD;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_GATE: begin
                if (wake_s) begin
                    state_d = ST_DEISO;
                end else begin
                    state_d = ST_ISO;
                    cnt_d   = ISO_LOAD;
                end
            end
            // ISO and RET are committed: wake is only looked at again in OFF.
            ST_ISO: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_RET;
                    cnt_d   = ISO_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_RET: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_OFF;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_OFF: begin
                if (wake_s) begin
                    state_d = ST_ON;
                    cnt_d   = PWR_LOAD;
                end else begin
                    state_d = ST_OFF;
                end
            end
            // Each cycle with PWRGOOD high consumes one settle count; a drop restarts it.
            ST_ON: begin
                if (~pmu.PWRGOOD) begin
                    cnt_d = PWR_LOAD;
                end else if (cnt_q <= 8'd1) begin
                    state_d = ST_RESTORE;
                    cnt_d   = ISO_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_RESTORE: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_DEISO;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_DEISO: begin
                state_d = ST_UNHOLD;
            end
            ST_UNHOLD: begin
                if (pmu.SLEEPHOLDACKn) begin
                    state_d = ST_WICREL;
                end else begin
                    state_d = ST_UNHOLD;
                end
            end
            ST_WICREL: begin
                if (~pmu.WICENACK) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_WICREL;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Output decode from the next state so outputs are registered with the state.
    always_comb begin
        wicenreq_d  = 1'b0;
        holdreqn_d  = 1'b1;
        gatehclk_d  = 1'b0;
        isolaten_d  = 1'b1;
        retainn_d   = 1'b1;
        pwrdwnreq_d = 1'b0;
        case (state_d)
            ST_RUN, ST_WICREL: begin
                wicenreq_d = 1'b0;
            end
            ST_WICREQ, ST_UNHOLD: begin
                wicenreq_d = 1'b1;
            end
            ST_HOLD, ST_DEISO: begin
                wicenreq_d = 1'b1;
                holdreqn_d = 1'b0;
            end
            ST_GATE: begin
                wicenreq_d = 1'b1;
                holdreqn_d = 1'b0;
                gatehclk_d = 1'b1;
            end
            ST_ISO, ST_RESTORE: begin
                wicenreq_d = 1'b1;
                holdreqn_d = 1'b0;
                gatehclk_d = 1'b1;
                isolaten_d = 1'b0;
            end
            ST_RET, ST_ON: begin
                wicenreq_d = 1'b1;
                holdreqn_d = 1'b0;
                gatehclk_d = 1'b1;
                isolaten_d = 1'b0;
                retainn_d  = 1'b0;
            end
            ST_OFF: begin
                wicenreq_d  = 1'b1;
                holdreqn_d  = 1'b0;
                gatehclk_d  = 1'b1;
                isolaten_d  = 1'b0;
                retainn_d   = 1'b0;
                pwrdwnreq_d = 1'b1;
            end
            default: begin
                wicenreq_d = 1'b0;
            end
        endcase
    end

    // State, counter and output registers; reset drops straight to RUN values.
    always_ff @(posedge FCLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q     <= ST_RUN;
            cnt_q       <= 8'd0;
            wicenreq_q  <= 1'b0;
            holdreqn_q  <= 1'b1;
            gatehclk_q  <= 1'b0;
            isolaten_q  <= 1'b1;
            retainn_q   <= 1'b1;
            pwrdwnreq_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wicenreq_q  <= wicenreq_d;
            holdreqn_q  <= holdreqn_d;
            gatehclk_q  <= gatehclk_d;
            isolaten_q  <= isolaten_d;
            retainn_q   <= retainn_d;
            pwrdwnreq_q <= pwrdwnreq_d;
        end
    end

    assign pmu.WICENREQ      = wicenreq_q;
    assign pmu.SLEEPHOLDREQn = holdreqn_q;
    assign pmu.GATEHCLK      = gatehclk_q;
    assign pmu.ISOLATEn      = isolaten_q;
    assign pmu.RETAINn       = retainn_q;
    assign pmu.PWRDWNREQ     = pwrdwnreq_q;
    assign pmu.PMUSTATE      = state_q;

endmodule

// File: tb/tb_cortexm0_sleep_pmu.sv
// Directed bench for cortexm0_sleep_pmu (ISO_DLY=2, PWR_DLY=8).
// Output vector order: {WICENREQ, SLEEPHOLDREQn, GATEHCLK, ISOLATEn, RETAINn, PWRDWNREQ}.
module tb_cortexm0_sleep_pmu;

    logic FCLK;
    logic nRESET;
    int   n_checks;
    int   n_fail;
    logic auto_wic;
    logic auto_hold;

    cortexm0_sleep_pmu_if bus ();

    cortexm0_sleep_pmu #(.ISO_DLY(2), .PWR_DLY(8)) dut (
        .FCLK   (FCLK),
        .nRESET (nRESET),
        .pmu    (bus.master)
    );

    initial FCLK = 1'b0;
    always #5 FCLK = ~FCLK;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] outs();
        return {bus.WICENREQ, bus.SLEEPHOLDREQn, bus.GATEHCLK,
                bus.ISOLATEn, bus.RETAINn, bus.PWRDWNREQ};
    endfunction

    // One clock; acks of the modelled WIC/core follow their requests one cycle later.
    task automatic tick();
        @(posedge FCLK);
        #1;
        if (auto_wic)  bus.WICENACK      = bus.WICENREQ;
        if (auto_hold) bus.SLEEPHOLDACKn = bus.SLEEPHOLDREQn;
    endtask

    task automatic step_st(input string tag, input logic [3:0] st);
        tick();
        chk_eq(tag, bus.PMUSTATE, st);
    endtask

    task automatic step_full(input string tag, input logic [3:0] st, input logic [5:0] ov);
        tick();
        chk_eq({tag, "_st"}, bus.PMUSTATE, st);
        chk_eq({tag, "_out"}, outs(), ov);
    endtask

    task automatic wait_state(input string tag, input logic [3:0] st, input int max_cyc);
        for (int i = 0; i < max_cyc && bus.PMUSTATE != st; i++) tick();
        chk_eq(tag, bus.PMUSTATE, st);
    endtask

    task automatic enter_to_off(input string tag);
        step_st(tag, 4'd1);
        step_st(tag, 4'd2);
        step_st(tag, 4'd3);
        step_st(tag, 4'd4);
        step_st(tag, 4'd4);
        step_st(tag, 4'd5);
        step_st(tag, 4'd5);
        step_full(tag, 4'd6, 6'b101001);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        auto_wic  = 1'b1;
        auto_hold = 1'b1;
        nRESET = 1'b0;
        bus.SLEEPING = 1'b0;
        bus.SLEEPDEEP = 1'b0;
        bus.DBGPWRUPREQ = 1'b0;
        bus.WAKEUP = 1'b0;
        bus.WICENACK = 1'b0;
        bus.SLEEPHOLDACKn = 1'b1;
        bus.PWRGOOD = 1'b1;
        #12;
        chk_eq("reset_out", outs(), 6'b010110);
        chk_eq("reset_st", bus.PMUSTATE, 4'd0);
        nRESET = 1'b1;
        step_full("idle", 4'd0, 6'b010110);

        // Test 1: full deep-sleep entry and exit
        bus.SLEEPING = 1'b1;
        bus.SLEEPDEEP = 1'b1;
        step_full("t1_wicreq", 4'd1, 6'b110110);
        step_full("t1_hold", 4'd2, 6'b100110);
        step_full("t1_gate", 4'd3, 6'b101110);
        step_full("t1_iso0", 4'd4, 6'b101010);
        step_full("t1_iso1", 4'd4, 6'b101010);
        step_full("t1_ret0", 4'd5, 6'b101000);
        step_full("t1_ret1", 4'd5, 6'b101000);
        step_full("t1_off", 4'd6, 6'b101001);
        bus.PWRGOOD = 1'b0;
        bus.WAKEUP = 1'b1;
        bus.SLEEPING = 1'b0;
        bus.SLEEPDEEP = 1'b0;
        step_full("t1_on", 4'd7, 6'b101000);
        bus.WAKEUP = 1'b0;
        for (int i = 0; i < 3; i++) step_st("t1_pgwait", 4'd7);
        bus.PWRGOOD = 1'b1;
        for (int i = 0; i < 7; i++) step_full("t1_settle", 4'd7, 6'b101000);
        step_full("t1_restore0", 4'd8, 6'b101010);
        step_full("t1_restore1", 4'd8, 6'b101010);
        step_full("t1_deiso", 4'd9, 6'b100110);
        step_full("t1_unhold", 4'd10, 6'b110110);
        step_full("t1_wicrel", 4'd11, 6'b010110);
        step_full("t1_run", 4'd0, 6'b010110);

        // Test 2: plain sleep never engages the WIC
        bus.SLEEPING = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk_eq("t2_plain", {bus.PMUSTATE, bus.WICENREQ}, 5'd0);
        end
        bus.SLEEPING = 1'b0;

        // Test 3: wake while the core has not granted the bus hold
        auto_hold = 1'b0;
        bus.SLEEPING = 1'b1;
        bus.SLEEPDEEP = 1'b1;
        step_full("t3_wicreq", 4'd1, 6'b110110);
        step_full("t3_hold", 4'd2, 6'b100110);
        bus.WAKEUP = 1'b1;
        step_full("t3_unhold", 4'd10, 6'b110110);
        step_full("t3_wicrel", 4'd11, 6'b010110);
        step_full("t3_run", 4'd0, 6'b010110);
        bus.WAKEUP = 1'b0;
        bus.SLEEPING = 1'b0;
        auto_hold = 1'b1;
        tick();

        // Test 4: wake during ISO is deferred until OFF
        bus.SLEEPING = 1'b1;
        step_st("t4", 4'd1);
        step_st("t4", 4'd2);
        step_st("t4", 4'd3);
        step_st("t4_iso", 4'd4);
        bus.WAKEUP = 1'b1;
        step_st("t4_iso1", 4'd4);
        step_st("t4_ret0", 4'd5);
        step_st("t4_ret1", 4'd5);
        step_full("t4_off", 4'd6, 6'b101001);
        bus.PWRGOOD = 1'b0;
        step_full("t4_on", 4'd7, 6'b101000);
        bus.PWRGOOD = 1'b1;
        bus.WAKEUP = 1'b0;
        bus.SLEEPING = 1'b0;
        for (int i = 0; i < 7; i++) step_st("t4_settle", 4'd7);
        step_st("t4_restore", 4'd8);
        wait_state("t4_run", 4'd0, 20);

        // Test 5: debug power request blocks entry and forces exit
        bus.DBGPWRUPREQ = 1'b1;
        bus.SLEEPING = 1'b1;
        for (int i = 0; i < 10; i++) step_st("t5_block", 4'd0);
        bus.DBGPWRUPREQ = 1'b0;
        enter_to_off("t5_entry");
        bus.PWRGOOD = 1'b0;
        bus.DBGPWRUPREQ = 1'b1;
        bus.SLEEPING = 1'b0;
        step_full("t5_on", 4'd7, 6'b101000);
        bus.PWRGOOD = 1'b1;
        for (int i = 0; i < 7; i++) step_st("t5_settle", 4'd7);
        step_full("t5_restore", 4'd8, 6'b101010);
        wait_state("t5_run", 4'd0, 20);
        bus.DBGPWRUPREQ = 1'b0;
        tick();

        // Test 7: PWRGOOD drop after three settle cycles restarts the count
        bus.SLEEPING = 1'b1;
        enter_to_off("t7_entry");
        bus.PWRGOOD = 1'b0;
        bus.WAKEUP = 1'b1;
        bus.SLEEPING = 1'b0;
        step_st("t7_on", 4'd7);
        bus.WAKEUP = 1'b0;
        bus.PWRGOOD = 1'b1;
        for (int i = 0; i < 3; i++) step_st("t7_pre", 4'd7);
        bus.PWRGOOD = 1'b0;
        step_st("t7_glitch", 4'd7);
        bus.PWRGOOD = 1'b1;
        for (int i = 0; i < 7; i++) step_st("t7_recount", 4'd7);
        step_st("t7_restore", 4'd8);
        wait_state("t7_run", 4'd0, 20);

        // Test 6: asynchronous reset while in RET
        bus.SLEEPING = 1'b1;
        step_st("t6", 4'd1);
        step_st("t6", 4'd2);
        step_st("t6", 4'd3);
        step_st("t6", 4'd4);
        step_st("t6", 4'd4);
        step_full("t6_ret", 4'd5, 6'b101000);
        #3;
        nRESET = 1'b0;
        #1;
        chk_eq("t6_async_out", outs(), 6'b010110);
        chk_eq("t6_async_st", bus.PMUSTATE, 4'd0);
        bus.SLEEPING = 1'b0;
        bus.SLEEPDEEP = 1'b0;
        bus.WICENACK = 1'b0;
        bus.SLEEPHOLDACKn = 1'b1;
        #2;
        nRESET = 1'b1;
        step_full("t6_after", 4'd0, 6'b010110);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
